cordic_rotator: RTL and testbench



---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_stage.sv | 51 +++++
 rtl/cordic_rotator.sv | 79 +++++++
 tb/tb_cordic_rotator.sv | 118 +++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants.
// Contents:
//   SZ_DEF  - default input width, which is also the pipeline depth
//   ANGLE_W - binary angle width; a full circle is 2^ANGLE_W
//   ATAN    - per-stage arctangent constants, round(atan(2^-i)/(2*pi)*2^32)
package cordic_pkg;
    localparam int SZ_DEF  = 16;
    localparam int ANGLE_W = 32;
    localparam logic [ANGLE_W-1:0] ATAN [15] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA
    };
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation by +/-atan(2^-SHIFT).
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   x_i, y_i, z_i - vector and residual angle from the previous register
//   x_o, y_o, z_o - registered rotated vector and updated residual angle
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                 SZ     = SZ_DEF,
    parameter int                 SHIFT  = 0,
    parameter logic [ANGLE_W-1:0] ATAN_C = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SZ:0]        x_i,
    input  logic [SZ:0]        y_i,
    input  logic [ANGLE_W-1:0] z_i,
    output logic [SZ:0]        x_o,
    output logic [SZ:0]        y_o,
    output logic [ANGLE_W-1:0] z_o
);
    logic [SZ:0]        x_d, y_d, x_q, y_q;
    logic [ANGLE_W-1:0] z_d, z_q;
    logic [SZ:0]        xs, ys;

    assign xs = $signed(x_i) >>> SHIFT;
    assign ys = $signed(y_i) >>> SHIFT;

    // A negative residual angle rotates clockwise, otherwise counter-clockwise.
    always_comb begin
        x_d = z_i[ANGLE_W-1] ? x_i + ys : x_i - ys;
        y_d = z_i[ANGLE_W-1] ? y_i - xs : y_i + xs;
        z_d = z_i[ANGLE_W-1] ? z_i + ATAN_C : z_i - ATAN_C;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign z_o = z_q;
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: fully pipelined rotation-mode CORDIC, one sample per clock, latency SZ.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (clears every pipeline register)
//   angle      - unsigned binary angle, full circle = 2^32
//   Xin, Yin   - signed SZ-bit input vector
//   Xout, Yout - signed SZ+1-bit rotated vector, CORDIC gain (~1.647) not compensated
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int SZ = SZ_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ANGLE_W-1:0] angle,
    input  logic [SZ-1:0]      Xin,
    input  logic [SZ-1:0]      Yin,
    output logic [SZ:0]        Xout,
    output logic [SZ:0]        Yout
);
    logic [SZ:0]        x_w [SZ];
    logic [SZ:0]        y_w [SZ];
    logic [ANGLE_W-1:0] z_w [SZ];
    logic [SZ:0]        x0_d, y0_d, x0_q, y0_q;
    logic [ANGLE_W-1:0] z0_d, z0_q;
    logic [SZ:0]        xe, ye;
    logic [1:0]         quad;
    logic               unused_z;

    assign xe   = {Xin[SZ-1], Xin};
    assign ye   = {Yin[SZ-1], Yin};
    assign quad = angle[ANGLE_W-1:ANGLE_W-2];

    // Pre-rotate by +/-90 degrees so the micro-rotations only cover [-90, +90].
    always_comb begin
        x0_d = quad == 2'b01 ? -ye : quad == 2'b10 ? ye : xe;
        y0_d = quad == 2'b01 ? xe : quad == 2'b10 ? -xe : ye;
        z0_d = quad == 2'b01 ? {2'b00, angle[ANGLE_W-3:0]} :
               quad == 2'b10 ? {2'b11, angle[ANGLE_W-3:0]} : angle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0_q <= '0;
            y0_q <= '0;
            z0_q <= '0;
        end else begin
            x0_q <= x0_d;
            y0_q <= y0_d;
            z0_q <= z0_d;
        end
    end

    assign x_w[0] = x0_q;
    assign y_w[0] = y0_q;
    assign z_w[0] = z0_q;

    for (genvar i = 0; i < SZ - 1; i++) begin : g_stage
        cordic_stage #(
            .SZ    (SZ),
            .SHIFT (i),
            .ATAN_C(ATAN[i])
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .x_i  (x_w[i]),
            .y_i  (y_w[i]),
            .z_i  (z_w[i]),
            .x_o  (x_w[i+1]),
            .y_o  (y_w[i+1]),
            .z_o  (z_w[i+1])
        );
    end

    // The final angle residue has no consumer.
    assign unused_z = ^z_w[SZ-1];

    assign Xout = x_w[SZ-1];
    assign Yout = y_w[SZ-1];
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed scoreboard bench for cordic_rotator against an ideal gain-scaled rotation.
module tb_cordic_rotator;
    localparam int    LAT = 16;
    localparam int    TOL = 8;
    localparam real   PI  = 3.14159265358979323846;

    typedef struct {
        int    x;
        int    y;
        int    tol;
        string tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [31:0]        angle = '0;
    logic [15:0]        Xin = '0;
    logic [15:0]        Yin = '0;
    logic signed [16:0] Xout, Yout;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    real  gain = 1.0;

    cordic_rotator dut (
        .clk  (clk),
        .rst_n(rst_n),
        .angle(angle),
        .Xin  (Xin),
        .Yin  (Yin),
        .Xout (Xout),
        .Yout (Yout)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    task automatic pop_check();
        exp_t   e;
        integer ax, ay;
        if (q.size() == LAT) begin
            e  = q.pop_front();
            ax = Xout;
            ay = Yout;
            checks++;
            assert (!$isunknown({Xout, Yout}) && ax - e.x <= e.tol && e.x - ax <= e.tol &&
                    ay - e.y <= e.tol && e.y - ay <= e.tol)
            else begin
                errors++;
                $error("FAIL %s: observed Xout=%0d Yout=%0d expected X=%0d Y=%0d tol=%0d",
                       e.tag, ax, ay, e.x, e.y, e.tol);
            end
        end
    endtask

    task automatic step(input logic [31:0] a, input int xi, input int yi, input string tag);
        real  th;
        exp_t e;
        th    = real'(a) * 2.0 * PI / 4294967296.0;
        rst_n = 1'b1;
        angle = a;
        Xin   = 16'(xi);
        Yin   = 16'(yi);
        e.x   = rnd(gain * (real'(xi) * $cos(th) - real'(yi) * $sin(th)));
        e.y   = rnd(gain * (real'(xi) * $sin(th) + real'(yi) * $cos(th)));
        e.tol = TOL;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // Reset zeroes the whole pipeline: the next LAT observations are exact zeros.
    task automatic rst_step(input logic [31:0] a, input int xi, input int yi);
        exp_t e;
        rst_n = 1'b0;
        angle = a;
        Xin   = 16'(xi);
        Yin   = 16'(yi);
        q.delete();
        for (int k = 0; k < LAT; k++) begin
            e.x   = 0;
            e.y   = 0;
            e.tol = 0;
            e.tag = $sformatf("reset_zero%0d", k);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        for (int i = 0; i < 15; i++) gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
        rst_step(32'h0, 0, 0);
        rst_step(32'h0, 0, 0);
        step(32'h00000000, 19429, 0, "ang0");
        step(32'h40000000, 19429, 0, "ang90");
        step(32'h80000000, 19429, 0, "ang180");
        step(32'hC0000000, 19429, 0, "ang270");
        step(32'h20000000, 19429, 0, "ang45");
        step(32'h40000000, 0, 19429, "yin_ang90");
        step(32'hA0000000, -12000, 7000, "mixed_ang225");
        step(32'hE0000000, 15000, -9000, "mixed_ang315");
        for (int i = 0; i < 360; i++) begin
            if (i == 200) rst_step(32'((64'(i) << 32) / 360), 19429, 0);
            step(32'((64'(i) << 32) / 360), 19429, 0, $sformatf("sweep%0d", i));
        end
        for (int i = 0; i < LAT; i++) step(32'h0, 0, 0, "drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
